multdiv_issue_ctrl: RTL and testbench

//   Processor-side initiator for the shared multiply/divide unit.
//   - Accepts one MULT/DIV request from decode and latches its operands and destination register.
//   - Pulses ctrl_MULT or ctrl_DIV for exactly one cycle.
//   - Stalls the pipeline until data_resultRDY is sampled.
//   - Presents the result, exception flag and destination register to writeback for one cycle.

---
 rtl/multdiv_pkg.sv | 35 +++
 rtl/multdiv_issue_ctrl_if.sv | 52 +++++
 rtl/multdiv_wait_counter.sv | 54 +++++
 rtl/multdiv_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_pkg
// Definitions shared by the multiply/divide issue controller, its wait
// counter and the interface that carries its bus signals.
//   state_e           : controller FSM encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//   OP_MULT / OP_DIV  : encoding of the latched operation select
//   DEFAULT_TIMEOUT   : WAIT cycles before a forced completion
//   DEFAULT_RDY_GUARD : leading WAIT cycles in which resultRDY is ignored
//   DATA_W / RD_W     : operand/result width and register-index width
//   opPulse()         : maps an operation select to the {div, mult} start pulse
// ---------------------------------------------------------------------------
package multdiv_pkg;

  localparam int DATA_W            = 32;
  localparam int RD_W              = 5;
  localparam int DEFAULT_TIMEOUT   = 64;
  localparam int DEFAULT_RDY_GUARD = 1;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Returns {ctrl_DIV, ctrl_MULT} for the given operation so exactly one of
  // the two start lines can ever be raised.
  function automatic logic [1:0] opPulse(input logic isDiv);
    return (isDiv == OP_DIV) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// multdiv_issue_ctrl_if
// Bundles every non-clock signal of the multiply/divide issue controller.
//   req_*        : decode request (valid, op select, operands, destination)
//   ctrl_*       : one-cycle start pulses to the shared unit
//   data_operand*: operands presented to the unit
//   data_result, data_exception, data_resultRDY : unit response
//   stall        : pipeline freeze
//   wb_*         : writeback strobe and captured result
// Modports:
//   master : the issue controller
//   slave  : the surrounding pipeline and the multiply/divide unit
// ---------------------------------------------------------------------------
interface multdiv_issue_ctrl_if;
  import multdiv_pkg::*;

  logic              req_valid;
  logic              req_is_div;
  logic [DATA_W-1:0] req_opA;
  logic [DATA_W-1:0] req_opB;
  logic [RD_W-1:0]   req_rd;

  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_operandB;
  logic [DATA_W-1:0] data_result;
  logic              data_exception;
  logic              data_resultRDY;

  logic              stall;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [RD_W-1:0]   wb_rd;
  logic              wb_exception;
  logic              wb_timeout;

  modport master (
    input  req_valid, req_is_div, req_opA, req_opB, req_rd,
    input  data_result, data_exception, data_resultRDY,
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output stall, wb_valid, wb_data, wb_rd, wb_exception, wb_timeout
  );

  modport slave (
    output req_valid, req_is_div, req_opA, req_opB, req_rd,
    output data_result, data_exception, data_resultRDY,
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  stall, wb_valid, wb_data, wb_rd, wb_exception, wb_timeout
  );

endinterface

// File: rtl/multdiv_wait_counter.sv
// ---------------------------------------------------------------------------
// multdiv_wait_counter
// Counts cycles spent waiting for the multiply/divide unit.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear_i      : force the count to zero (has priority over enable_i)
//   enable_i     : advance the count by one
//   guardMet_o   : count has reached RDY_GUARD, resultRDY may be trusted
//   expired_o    : count equals TIMEOUT-1, the wait must be abandoned
// ---------------------------------------------------------------------------
module multdiv_wait_counter
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int RDY_GUARD = DEFAULT_RDY_GUARD
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic guardMet_o,
  output logic expired_o
);

  localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, and the count saturates at TIMEOUT-1 so it can
  // never wrap back into the guarded region while the controller leaves WAIT.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Status flags are pure decodes of the registered count.
  assign expired_o  = (count_q == LAST);
  assign guardMet_o = ({{(32-CNT_W){1'b0}}, count_q} >= 32'(RDY_GUARD));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_issue_ctrl
// Processor-side initiator for the shared multiply/divide unit. Takes one
// request from decode, pulses the matching start line for one cycle, stalls
// the pipeline until the unit answers (or a timeout fires) and then presents
// the captured result to writeback for one cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : multdiv_issue_ctrl_if.master (request, unit and writeback)
// Parameters:
//   TIMEOUT   : WAIT cycles before a forced completion with exception (>=2)
//   RDY_GUARD : leading WAIT cycles in which data_resultRDY is ignored
// ---------------------------------------------------------------------------
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int RDY_GUARD = DEFAULT_RDY_GUARD
) (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_issue_ctrl_if.master bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opA_q, opA_d;
  logic [DATA_W-1:0] opB_q, opB_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              isDiv_q, isDiv_d;
  logic [DATA_W-1:0] wbData_q, wbData_d;
  logic [RD_W-1:0]   wbRd_q, wbRd_d;
  logic              wbExc_q, wbExc_d;
  logic              wbTimeout_q, wbTimeout_d;

  logic cntClear;
  logic cntEnable;
  logic guardMet;
  logic expired;

  multdiv_wait_counter #(
    .TIMEOUT   (TIMEOUT),
    .RDY_GUARD (RDY_GUARD)
  ) u_waitCounter (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (cntClear),
    .enable_i   (cntEnable),
    .guardMet_o (guardMet),
    .expired_o  (expired)
  );

  // Next-state and capture logic. Operands are latched only when a request
  // is accepted in IDLE, so they stay stable for the whole operation. In
  // WAIT a trusted resultRDY is checked before the timeout so that a result
  // arriving on the last allowed cycle is still delivered normally.
  always_comb begin
    state_d     = state_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    rd_d        = rd_q;
    isDiv_d     = isDiv_q;
    wbData_d    = wbData_q;
    wbRd_d      = wbRd_q;
    wbExc_d     = wbExc_q;
    wbTimeout_d = wbTimeout_q;
    cntClear    = 1'b0;
    cntEnable   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          opA_d   = bus.req_opA;
          opB_d   = bus.req_opB;
          rd_d    = bus.req_rd;
          isDiv_d = bus.req_is_div;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cntClear = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cntEnable = 1'b1;
        if (bus.data_resultRDY && guardMet) begin
          wbData_d    = bus.data_result;
          wbRd_d      = rd_q;
          wbExc_d     = bus.data_exception;
          wbTimeout_d = 1'b0;
          state_d     = ST_DONE;
        end else if (expired) begin
          wbData_d    = '0;
          wbRd_d      = rd_q;
          wbExc_d     = 1'b1;
          wbTimeout_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and writeback registers. Reset clears everything so a
  // reset in the middle of an operation never produces a writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      rd_q        <= '0;
      isDiv_q     <= OP_MULT;
      wbData_q    <= '0;
      wbRd_q      <= '0;
      wbExc_q     <= 1'b0;
      wbTimeout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      rd_q        <= rd_d;
      isDiv_q     <= isDiv_d;
      wbData_q    <= wbData_d;
      wbRd_q      <= wbRd_d;
      wbExc_q     <= wbExc_d;
      wbTimeout_q <= wbTimeout_d;
    end
  end

  // Start pulses exist only in ISSUE; stall drops in DONE so the pipeline
  // advances together with the writeback.
  assign {bus.ctrl_DIV, bus.ctrl_MULT} = (state_q == ST_ISSUE) ? opPulse(isDiv_q) : 2'b00;

  assign bus.stall = ((state_q == ST_IDLE) && bus.req_valid)
                   || (state_q == ST_ISSUE)
                   || (state_q == ST_WAIT);

  assign bus.data_operandA = opA_q;
  assign bus.data_operandB = opB_q;
  assign bus.wb_valid      = (state_q == ST_DONE);
  assign bus.wb_data       = wbData_q;
  assign bus.wb_rd         = wbRd_q;
  assign bus.wb_exception  = wbExc_q;
  assign bus.wb_timeout    = wbTimeout_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multdiv_issue_ctrl
// Directed bench for multdiv_issue_ctrl. The bench plays the role of the
// multiply/divide unit, computes the arithmetic itself and keeps a queue of
// expected writebacks that is drained whenever wb_valid is observed.
// ---------------------------------------------------------------------------
module tb_multdiv_issue_ctrl;

  localparam int TB_TIMEOUT   = 64;
  localparam int TB_RDY_GUARD = 1;
  localparam int WAIT_BUDGET  = 200;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
    logic        tmo;
    int          doneK;
  } expect_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  expect_t sb[$];

  multdiv_issue_ctrl_if bus ();

  multdiv_issue_ctrl #(
    .TIMEOUT   (TB_TIMEOUT),
    .RDY_GUARD (TB_RDY_GUARD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and counts and reports it when it fails.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Every output of the controller must be zero.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"},    32'(bus.stall),        32'd0);
    checkOutput({tag, "_mult"},     32'(bus.ctrl_MULT),    32'd0);
    checkOutput({tag, "_div"},      32'(bus.ctrl_DIV),     32'd0);
    checkOutput({tag, "_wbvalid"},  32'(bus.wb_valid),     32'd0);
    checkOutput({tag, "_wbdata"},   bus.wb_data,           32'd0);
    checkOutput({tag, "_wbrd"},     32'(bus.wb_rd),        32'd0);
    checkOutput({tag, "_wbexc"},    32'(bus.wb_exception), 32'd0);
    checkOutput({tag, "_wbtmo"},    32'(bus.wb_timeout),   32'd0);
    checkOutput({tag, "_operandA"}, bus.data_operandA,     32'd0);
    checkOutput({tag, "_operandB"}, bus.data_operandB,     32'd0);
  endtask

  // Runs one operation from request to writeback. rdyDelay is the cycle
  // after the start pulse on which the unit raises RDY (<=0 means never).
  // staleRdy keeps RDY high with garbage from the request through the first
  // WAIT cycle. fromDone drives the request during the previous DONE cycle;
  // stayInDone returns while the DUT is still in DONE.
  task automatic applyStimulus(input string tag, input logic isDiv,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int rdyDelay,
                               input bit staleRdy, input bit fromDone, input bit stayInDone);
    expect_t     e;
    expect_t     got;
    logic [31:0] unitResult;
    logic        unitExc;
    logic        expMult;
    int          k;
    bit          seenDone;
    bit          bad;

    unitResult = isDiv ? ((b == 32'd0) ? 32'd0 : a / b) : a * b;
    unitExc    = isDiv && (b == 32'd0);
    if (rdyDelay > 0) e = '{unitResult, rd, unitExc, 1'b0, rdyDelay + 1};
    else              e = '{32'd0, rd, 1'b1, 1'b1, TB_TIMEOUT + 1};
    sb.push_back(e);

    bus.req_valid      = 1'b1;
    bus.req_is_div     = isDiv;
    bus.req_opA        = a;
    bus.req_opB        = b;
    bus.req_rd         = rd;
    bus.data_resultRDY = staleRdy;
    bus.data_result    = 32'hDEAD_BEEF;
    bus.data_exception = staleRdy;
    if (fromDone) @(negedge clock);
    #1;
    checkOutput({tag, "_req_stall"}, 32'(bus.stall), 32'd1);
    checkOutput({tag, "_req_nopulse"}, 32'({bus.ctrl_DIV, bus.ctrl_MULT}), 32'd0);

    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_opA   = 32'hFFFF_FFFF;
    bus.req_opB   = 32'hFFFF_FFFF;
    bus.req_rd    = 5'h1F;
    #1;
    expMult = ~isDiv;
    checkOutput({tag, "_issue_mult"}, 32'(bus.ctrl_MULT), 32'(expMult));
    checkOutput({tag, "_issue_div"},  32'(bus.ctrl_DIV),  32'(isDiv));
    checkOutput({tag, "_issue_opA"},  bus.data_operandA,  a);
    checkOutput({tag, "_issue_opB"},  bus.data_operandB,  b);

    k        = 0;
    seenDone = 1'b0;
    bad      = 1'b0;
    while (!seenDone && k < WAIT_BUDGET) begin
      @(negedge clock);
      k++;
      bus.data_resultRDY = (k == rdyDelay) || (staleRdy && k == 1);
      bus.data_result    = (k == rdyDelay) ? unitResult : 32'hDEAD_BEEF;
      bus.data_exception = (k == rdyDelay) ? unitExc : 1'b1;
      #1;
      if (bus.wb_valid === 1'b1) seenDone = 1'b1;
      else if (bus.stall !== 1'b1 || bus.ctrl_MULT !== 1'b0 || bus.ctrl_DIV !== 1'b0
               || bus.data_operandA !== a || bus.data_operandB !== b) bad = 1'b1;
    end
    checkOutput({tag, "_wait_quiet"}, 32'(bad), 32'd0);
    checkOutput({tag, "_done_seen"}, 32'(seenDone), 32'd1);

    if (seenDone) begin
      checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        checkOutput({tag, "_latency"}, 32'(k),                 32'(got.doneK));
        checkOutput({tag, "_wbdata"},  bus.wb_data,            got.data);
        checkOutput({tag, "_wbrd"},    32'(bus.wb_rd),         32'(got.rd));
        checkOutput({tag, "_wbexc"},   32'(bus.wb_exception),  32'(got.exc));
        checkOutput({tag, "_wbtmo"},   32'(bus.wb_timeout),    32'(got.tmo));
        checkOutput({tag, "_done_stall"}, 32'(bus.stall),      32'd0);
        checkOutput({tag, "_done_nopulse"}, 32'({bus.ctrl_DIV, bus.ctrl_MULT}), 32'd0);
      end
    end

    if (!stayInDone) begin
      @(negedge clock);
      #1;
      checkOutput({tag, "_idle_wbvalid"}, 32'(bus.wb_valid), 32'd0);
      checkOutput({tag, "_idle_stall"},   32'(bus.stall),    32'd0);
      checkOutput({tag, "_idle_hold"},    bus.wb_data,       e.data);
    end
  endtask

  // Directed sequence.
  initial begin
    bit sawWb;

    checks             = 0;
    errors             = 0;
    reset              = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_is_div     = 1'b0;
    bus.req_opA        = 32'd0;
    bus.req_opB        = 32'd0;
    bus.req_rd         = 5'd0;
    bus.data_result    = 32'd0;
    bus.data_exception = 1'b0;
    bus.data_resultRDY = 1'b0;

    $display("[TB] reset");
    repeat (3) @(negedge clock);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("post_reset_stall", 32'(bus.stall), 32'd0);

    $display("[TB] mult 7*6, RDY 32 cycles after pulse");
    applyStimulus("mul7x6", 1'b0, 32'd7, 32'd6, 5'd3, 32, 1'b0, 1'b0, 1'b0);

    $display("[TB] div 100/7 with stale RDY");
    applyStimulus("div100by7", 1'b1, 32'd100, 32'd7, 5'd4, 5, 1'b1, 1'b0, 1'b0);

    $display("[TB] div 5/0 with exception");
    applyStimulus("div5by0", 1'b1, 32'd5, 32'd0, 5'd5, 3, 1'b0, 1'b0, 1'b0);

    $display("[TB] RDY on the timeout cycle");
    applyStimulus("rdy_at_limit", 1'b0, 32'd123, 32'd456, 5'd6, TB_TIMEOUT, 1'b0, 1'b0, 1'b0);

    $display("[TB] unit never answers");
    applyStimulus("timeout", 1'b1, 32'd8, 32'd2, 5'd7, -1, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset in WAIT");
    bus.req_valid  = 1'b1;
    bus.req_is_div = 1'b0;
    bus.req_opA    = 32'd11;
    bus.req_opB    = 32'd13;
    bus.req_rd     = 5'd9;
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkAllZero("midreset");
    sawWb = 1'b0;
    repeat (4) begin
      @(negedge clock);
      #1;
      if (bus.wb_valid === 1'b1) sawWb = 1'b1;
    end
    checkOutput("midreset_no_wb", 32'(sawWb), 32'd0);
    applyStimulus("mul3x3", 1'b0, 32'd3, 32'd3, 5'd8, 4, 1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back requests");
    applyStimulus("b2b_mul2x3", 1'b0, 32'd2, 32'd3, 5'd10, 2, 1'b0, 1'b0, 1'b1);
    applyStimulus("b2b_div9by3", 1'b1, 32'd9, 32'd3, 5'd11, 2, 1'b0, 1'b1, 1'b0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
